i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 200000, meaning the maximum clk cycles to wait for mDone before aborting.
REQ-002 The block SHALL have parameter NUM_REQ, default 2, meaning the number of requesters (fixed at 2).
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 reqValid  in  2  per-requester request; held high with stable fields until accepted.
REQ-006 reqRw  in  2  per-requester direction, 1 read, 0 write.
REQ-007 reqAddr  in  14  {req1[6:0], req0[6:0]} 7-bit slave addresses.
REQ-008 reqDin  in  16  {req1[7:0], req0[7:0]} write data.
REQ-009 reqAccept  out  2  one-cycle pulse, request of that index taken.
REQ-010 rspValid  out  2  one-cycle pulse, response for that index valid.
REQ-011 rspData  out  8  read data, valid with any rspValid bit.
REQ-012 rspStatus  out  2  00 OK, 01 NACK, 10 TIMEOUT; valid with rspValid.
REQ-013 arbBusy  out  1  high whenever state is not IDLE.
REQ-014 mRw, mAddr(7), mDin(8), mDataValid  out  command fields driven to the I2C master.
REQ-015 mDout(8), mBusy, mAckErr, mDone  in  status returned by the I2C master.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE, RESPOND; all outputs SHALL be registered.
REQ-017 IDLE: when any reqValid is high and mBusy is low, the block SHALL select a grantee, latch its rw/addr/din, and go to ISSUE.
REQ-018 IDLE with mBusy high SHALL grant nothing and hold.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, the index not served last wins; after reset, index 0 has priority.
REQ-020 A single requesting index SHALL be granted regardless of pointer.
REQ-021 ISSUE (one cycle): mDataValid=1 with latched fields and reqAccept[grantee]=1; next state WAIT_DONE.
REQ-022 mDataValid and reqAccept SHALL each be high for exactly one cycle per transaction.
REQ-023 mRw/mAddr/mDin SHALL hold latched values from ISSUE until return to IDLE.
REQ-024 WAIT_DONE: a timeout counter SHALL start at 0 and increment each cycle.
REQ-025 On mDone=1, the block SHALL capture mDout and status (mAckErr -> 01, otherwise 00) and go to RESPOND.
REQ-026 If the counter reaches TIMEOUT_CYCLES-1 without mDone, the block SHALL go to RESPOND with status 10 and rspData=0.
REQ-027 If mDone and the timeout occur in the same cycle, mDone SHALL win.
REQ-028 RESPOND (one cycle): rspValid[grantee]=1 with rspData/rspStatus; the round-robin pointer SHALL update to the grantee; next state IDLE.
REQ-029 rspData and rspStatus SHALL hold their values until the next RESPOND.
REQ-030 Latency SHALL be: request sampled in cycle N -> reqAccept/mDataValid in N+1 -> rspValid one cycle after mDone is sampled.
REQ-031 Dropping reqValid before accept SHALL withdraw the request with no side effect.
REQ-032 Changes to reqValid or fields after accept SHALL be ignored until IDLE.
REQ-033 A new request SHALL be evaluated in the first IDLE cycle after RESPOND, so back-to-back transactions have a 1-cycle IDLE gap.

Reset
REQ-034 On rst low, state SHALL be IDLE, the pointer SHALL favor index 0, and the counter SHALL be 0.
REQ-035 On rst low, all outputs SHALL be 0: reqAccept, rspValid, rspData, rspStatus, arbBusy, mRw, mAddr, mDin, mDataValid.
REQ-036 Reset mid-transaction SHALL abort without any rspValid; the master is reset by the same rst.

Structure
REQ-037 A shared package i2c_pkg SHALL hold the state enum, the rspStatus encodings, and the default TIMEOUT_CYCLES.
REQ-038 The 2-way round-robin grant logic SHALL be a sub-module, rr_arbiter2: inputs request, pointer; output one-hot grant.

Verification
REQ-039 Scenario: req0 write addr 0x50 din 0xA5, master returns mDone with mAckErr=0 -> mAddr=0x50, mDin=0xA5, mRw=0, one mDataValid pulse; rspValid[0] with status 00.
REQ-040 Scenario: both requesters valid from reset -> req0 served first, then req1; repeat -> order alternates 0,1,0,1.
REQ-041 Scenario: req1 read, master returns mDout=0x3C with mAckErr=1 -> rspValid[1], rspData=0x3C, status 01.
REQ-042 Scenario: TIMEOUT_CYCLES=16, master never asserts mDone -> rspValid exactly 16 cycles after entering WAIT_DONE, status 10, rspData=0, then IDLE.
REQ-043 Scenario: mBusy held high while req0 valid -> no reqAccept until mBusy falls, then accept in the next cycle.
REQ-044 Scenario: rst asserted during WAIT_DONE -> all outputs 0 immediately, no rspValid; after release, a fresh req1 is granted normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C request arbiter: FSM states, response
// status codes and the default transaction timeout.
package i2c_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      RESPOND   = 2'd3
   } arbState_e;

   localparam logic [1:0] STATUS_OK      = 2'b00;
   localparam logic [1:0] STATUS_NACK    = 2'b01;
   localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

   localparam int DEFAULT_TIMEOUT_CYCLES = 200000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. The pointer names the index served last, so on
// a tie the other index wins; a lone requester always wins.
module rr_arbiter2 (
   input  logic [1:0] request,
   input  logic       pointer,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (request)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = pointer ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/i2c_arbiter.sv
// Arbitrates two requesters onto one I2C master: latch the winner's command,
// issue it for one cycle, wait for completion or timeout, then respond.
module i2c_arbiter
   import i2c_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int NUM_REQ        = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   reqValid,
   input  logic [NUM_REQ-1:0]   reqRw,
   input  logic [7*NUM_REQ-1:0] reqAddr,
   input  logic [8*NUM_REQ-1:0] reqDin,
   output logic [NUM_REQ-1:0]   reqAccept,
   output logic [NUM_REQ-1:0]   rspValid,
   output logic [7:0]           rspData,
   output logic [1:0]           rspStatus,
   output logic                 arbBusy,
   output logic                 mRw,
   output logic [6:0]           mAddr,
   output logic [7:0]           mDin,
   output logic                 mDataValid,
   input  logic [7:0]           mDout,
   input  logic                 mBusy,
   input  logic                 mAckErr,
   input  logic                 mDone
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arbState_e          stateQ, stateD;
   logic [CNT_W-1:0]   cntQ, cntD;
   logic               grantIdxQ, grantIdxD;
   logic               lastServedQ, lastServedD;
   logic [NUM_REQ-1:0] reqAcceptQ, reqAcceptD;
   logic [NUM_REQ-1:0] rspValidQ, rspValidD;
   logic [7:0]         rspDataQ, rspDataD;
   logic [1:0]         rspStatusQ, rspStatusD;
   logic               arbBusyQ, arbBusyD;
   logic               mRwQ, mRwD;
   logic [6:0]         mAddrQ, mAddrD;
   logic [7:0]         mDinQ, mDinD;
   logic               mDataValidQ, mDataValidD;
   logic [1:0]         grant;

   rr_arbiter2 uRrArbiter (
      .request (reqValid),
      .pointer (lastServedQ),
      .grant   (grant)
   );

   // Every output is computed one state ahead and registered, so pulses line
   // up with the state they belong to (accept in ISSUE, response in RESPOND).
   always_comb begin
      stateD      = stateQ;
      cntD        = cntQ;
      grantIdxD   = grantIdxQ;
      lastServedD = lastServedQ;
      reqAcceptD  = '0;
      rspValidD   = '0;
      rspDataD    = rspDataQ;
      rspStatusD  = rspStatusQ;
      mRwD        = mRwQ;
      mAddrD      = mAddrQ;
      mDinD       = mDinQ;
      mDataValidD = 1'b0;
      case (stateQ)
         IDLE: begin
            if ((|reqValid) && !mBusy) begin
               stateD      = ISSUE;
               grantIdxD   = grant[1];
               mRwD        = reqRw[grant[1]];
               mAddrD      = grant[1] ? reqAddr[13:7] : reqAddr[6:0];
               mDinD       = grant[1] ? reqDin[15:8]  : reqDin[7:0];
               mDataValidD = 1'b1;
               reqAcceptD  = grant;
            end
         end
         ISSUE: begin
            stateD = WAIT_DONE;
            cntD   = '0;
         end
         WAIT_DONE: begin
            // A completion in the final timeout cycle still counts as a completion.
            if (mDone) begin
               stateD                 = RESPOND;
               rspDataD               = mDout;
               rspStatusD             = mAckErr ? STATUS_NACK : STATUS_OK;
               rspValidD[grantIdxQ]   = 1'b1;
            end else if (cntQ == CNT_LAST) begin
               stateD                 = RESPOND;
               rspDataD               = 8'h00;
               rspStatusD             = STATUS_TIMEOUT;
               rspValidD[grantIdxQ]   = 1'b1;
            end else begin
               cntD = cntQ + CNT_W'(1);
            end
         end
         RESPOND: begin
            stateD      = IDLE;
            lastServedD = grantIdxQ;
         end
         default: stateD = IDLE;
      endcase
      arbBusyD = (stateD != IDLE);
   end

   // Pointer resets to 1 so that index 0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ      <= IDLE;
         cntQ        <= '0;
         grantIdxQ   <= 1'b0;
         lastServedQ <= 1'b1;
         reqAcceptQ  <= '0;
         rspValidQ   <= '0;
         rspDataQ    <= 8'h00;
         rspStatusQ  <= STATUS_OK;
         arbBusyQ    <= 1'b0;
         mRwQ        <= 1'b0;
         mAddrQ      <= 7'h00;
         mDinQ       <= 8'h00;
         mDataValidQ <= 1'b0;
      end else begin
         stateQ      <= stateD;
         cntQ        <= cntD;
         grantIdxQ   <= grantIdxD;
         lastServedQ <= lastServedD;
         reqAcceptQ  <= reqAcceptD;
         rspValidQ   <= rspValidD;
         rspDataQ    <= rspDataD;
         rspStatusQ  <= rspStatusD;
         arbBusyQ    <= arbBusyD;
         mRwQ        <= mRwD;
         mAddrQ      <= mAddrD;
         mDinQ       <= mDinD;
         mDataValidQ <= mDataValidD;
      end
   end

   assign reqAccept  = reqAcceptQ;
   assign rspValid   = rspValidQ;
   assign rspData    = rspDataQ;
   assign rspStatus  = rspStatusQ;
   assign arbBusy    = arbBusyQ;
   assign mRw        = mRwQ;
   assign mAddr      = mAddrQ;
   assign mDin       = mDinQ;
   assign mDataValid = mDataValidQ;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: the bench plays both requesters and the
// I2C master, and checks each cycle against hand-computed values.
module tb_i2c_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  reqValid;
   logic [1:0]  reqRw;
   logic [13:0] reqAddr;
   logic [15:0] reqDin;
   logic [1:0]  reqAccept;
   logic [1:0]  rspValid;
   logic [7:0]  rspData;
   logic [1:0]  rspStatus;
   logic        arbBusy;
   logic        mRw;
   logic [6:0]  mAddr;
   logic [7:0]  mDin;
   logic        mDataValid;
   logic [7:0]  mDout;
   logic        mBusy;
   logic        mAckErr;
   logic        mDone;

   int testsRun  = 0;
   int failCount = 0;

   i2c_arbiter #(.TIMEOUT_CYCLES(16), .NUM_REQ(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .reqValid   (reqValid),
      .reqRw      (reqRw),
      .reqAddr    (reqAddr),
      .reqDin     (reqDin),
      .reqAccept  (reqAccept),
      .rspValid   (rspValid),
      .rspData    (rspData),
      .rspStatus  (rspStatus),
      .arbBusy    (arbBusy),
      .mRw        (mRw),
      .mAddr      (mAddr),
      .mDin       (mDin),
      .mDataValid (mDataValid),
      .mDout      (mDout),
      .mBusy      (mBusy),
      .mAckErr    (mAckErr),
      .mDone      (mDone)
   );

   always #5 clk = ~clk;

   // Outputs are sampled 1 time unit after the rising edge, where they are stable.
   task automatic waitCycle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rw,
                                input logic [13:0] addr, input logic [15:0] din);
      reqValid = valid;
      reqRw    = rw;
      reqAddr  = addr;
      reqDin   = din;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".reqAccept"},  32'(reqAccept),  32'h0);
      checkOutput({tag, ".rspValid"},   32'(rspValid),   32'h0);
      checkOutput({tag, ".rspData"},    32'(rspData),    32'h0);
      checkOutput({tag, ".rspStatus"},  32'(rspStatus),  32'h0);
      checkOutput({tag, ".arbBusy"},    32'(arbBusy),    32'h0);
      checkOutput({tag, ".mRw"},        32'(mRw),        32'h0);
      checkOutput({tag, ".mAddr"},      32'(mAddr),      32'h0);
      checkOutput({tag, ".mDin"},       32'(mDin),       32'h0);
      checkOutput({tag, ".mDataValid"}, 32'(mDataValid), 32'h0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired before end of stimulus");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b0;
      applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
      mDout = 8'h00; mBusy = 1'b0; mAckErr = 1'b0; mDone = 1'b0;
      waitCycle(2);
      checkAllZero("reset");
      rst = 1'b1;
      waitCycle(1);

      // Single write from requester 0, OK completion.
      applyStimulus(2'b01, 2'b00, {7'h00, 7'h50}, {8'h00, 8'hA5});
      waitCycle(1);
      checkOutput("w0.accept",    32'(reqAccept),  32'h1);
      checkOutput("w0.dataValid", 32'(mDataValid), 32'h1);
      checkOutput("w0.mAddr",     32'(mAddr),      32'h50);
      checkOutput("w0.mDin",      32'(mDin),       32'hA5);
      checkOutput("w0.mRw",       32'(mRw),        32'h0);
      checkOutput("w0.busy",      32'(arbBusy),    32'h1);
      applyStimulus(2'b10, 2'b11, {7'h7F, 7'h7F}, 16'hFFFF);
      waitCycle(1);
      checkOutput("w0.dvPulse",   32'(mDataValid), 32'h0);
      checkOutput("w0.accPulse",  32'(reqAccept),  32'h0);
      checkOutput("w0.addrHold",  32'(mAddr),      32'h50);
      applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
      mDout = 8'h11; mDone = 1'b1;
      waitCycle(1);
      checkOutput("w0.rspValid",  32'(rspValid),   32'h1);
      checkOutput("w0.status",    32'(rspStatus),  32'h0);
      checkOutput("w0.rspData",   32'(rspData),    32'h11);
      mDone = 1'b0;
      waitCycle(1);
      checkOutput("w0.rspPulse",  32'(rspValid),   32'h0);
      checkOutput("w0.idle",      32'(arbBusy),    32'h0);
      checkOutput("w0.dataHold",  32'(rspData),    32'h11);

      // Both requesters held from reset: order alternates 0,1,0,1.
      rst = 1'b0;
      waitCycle(1);
      rst = 1'b1;
      applyStimulus(2'b11, 2'b00, {7'h21, 7'h20}, {8'hB1, 8'hB0});
      for (int t = 0; t < 4; t++) begin
         waitCycle(1);
         checkOutput($sformatf("rr%0d.accept", t), 32'(reqAccept), ((t % 2) == 0) ? 32'h1 : 32'h2);
         checkOutput($sformatf("rr%0d.mAddr", t), 32'(mAddr), ((t % 2) == 0) ? 32'h20 : 32'h21);
         waitCycle(1);
         mDone = 1'b1;
         waitCycle(1);
         checkOutput($sformatf("rr%0d.rspValid", t), 32'(rspValid), ((t % 2) == 0) ? 32'h1 : 32'h2);
         mDone = 1'b0;
         waitCycle(1);
         checkOutput($sformatf("rr%0d.gapBusy", t), 32'(arbBusy), 32'h0);
         checkOutput($sformatf("rr%0d.gapAccept", t), 32'(reqAccept), 32'h0);
      end
      applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
      waitCycle(1);

      // Requester 1 read, master NACKs with data 0x3C.
      applyStimulus(2'b10, 2'b10, {7'h22, 7'h00}, 16'h0);
      waitCycle(1);
      checkOutput("r1.accept", 32'(reqAccept), 32'h2);
      checkOutput("r1.mRw",    32'(mRw),       32'h1);
      checkOutput("r1.mAddr",  32'(mAddr),     32'h22);
      applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
      waitCycle(1);
      mDone = 1'b1; mAckErr = 1'b1; mDout = 8'h3C;
      waitCycle(1);
      checkOutput("r1.rspValid", 32'(rspValid),  32'h2);
      checkOutput("r1.rspData",  32'(rspData),   32'h3C);
      checkOutput("r1.status",   32'(rspStatus), 32'h1);
      mDone = 1'b0; mAckErr = 1'b0;
      waitCycle(1);

      // Timeout: no mDone, response 16 cycles after entering WAIT_DONE.
      applyStimulus(2'b01, 2'b00, {7'h00, 7'h11}, {8'h00, 8'h5A});
      waitCycle(1);
      applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
      waitCycle(1);
      for (int k = 1; k < 16; k++) begin
         waitCycle(1);
         checkOutput($sformatf("to.early%0d", k), 32'(rspValid), 32'h0);
      end
      waitCycle(1);
      checkOutput("to.rspValid", 32'(rspValid),  32'h1);
      checkOutput("to.status",   32'(rspStatus), 32'h2);
      checkOutput("to.rspData",  32'(rspData),   32'h0);
      waitCycle(1);
      checkOutput("to.idle",     32'(arbBusy),   32'h0);

      // mDone in the final timeout cycle beats the timeout.
      applyStimulus(2'b10, 2'b00, {7'h12, 7'h00}, 16'h0);
      waitCycle(1);
      applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
      waitCycle(16);
      mDone = 1'b1; mDout = 8'h77;
      waitCycle(1);
      checkOutput("tie.rspValid", 32'(rspValid),  32'h2);
      checkOutput("tie.status",   32'(rspStatus), 32'h0);
      checkOutput("tie.rspData",  32'(rspData),   32'h77);
      mDone = 1'b0;
      waitCycle(1);

      // Withdrawn request while master busy leaves no trace.
      mBusy = 1'b1;
      applyStimulus(2'b01, 2'b00, {7'h00, 7'h44}, 16'h0);
      waitCycle(1);
      applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
      mBusy = 1'b0;
      waitCycle(1);
      checkOutput("wd.accept", 32'(reqAccept), 32'h0);
      checkOutput("wd.busy",   32'(arbBusy),   32'h0);

      // Master busy blocks grant until it falls.
      mBusy = 1'b1;
      applyStimulus(2'b01, 2'b00, {7'h00, 7'h45}, {8'h00, 8'h66});
      for (int b = 0; b < 3; b++) begin
         waitCycle(1);
         checkOutput($sformatf("mb.hold%0d", b), 32'(reqAccept), 32'h0);
      end
      mBusy = 1'b0;
      waitCycle(1);
      checkOutput("mb.accept", 32'(reqAccept), 32'h1);
      checkOutput("mb.mAddr",  32'(mAddr),     32'h45);
      applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
      waitCycle(1);
      mDone = 1'b1; mDout = 8'h99;
      waitCycle(1);
      mDone = 1'b0;
      waitCycle(1);

      // Reset during WAIT_DONE aborts with no response.
      applyStimulus(2'b01, 2'b01, {7'h00, 7'h33}, {8'h00, 8'h44});
      waitCycle(1);
      applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
      waitCycle(2);
      rst = 1'b0;
      #1;
      checkAllZero("midReset");
      mDone = 1'b1;
      waitCycle(1);
      checkOutput("midReset.noRsp", 32'(rspValid), 32'h0);
      mDone = 1'b0;
      rst = 1'b1;
      applyStimulus(2'b10, 2'b00, {7'h55, 7'h00}, {8'hCC, 8'h00});
      waitCycle(1);
      checkOutput("post.accept", 32'(reqAccept), 32'h2);
      checkOutput("post.mDin",   32'(mDin),      32'hCC);
      applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
      waitCycle(1);
      mDone = 1'b1; mDout = 8'h00;
      waitCycle(1);
      checkOutput("post.rspValid", 32'(rspValid), 32'h2);
      mDone = 1'b0;
      waitCycle(2);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
